reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular in-order buffer for the Tomasulo core.
- Allocates one entry per dispatched instruction and tags it with a ROB tag.
- Captures CDB results and retires completed entries in program order, one per cycle.
- Is the producer of ROB_MAP_PACKET, which the map table consumes, and the consumer of MAP_ROB_PACKET, which the map table returns; it supplies operand values for renamed sources that have already completed.

Parameters:
- ROB_SZ, 8: number of entries; must be a power of two, ≥2.
- TAG_W, $clog2(ROB_SZ+1): ROB tag width; tag 0 is reserved for "no tag / value in regfile".

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- dispatch_valid  in  1  RS accepted an instruction this cycle
- dp_packet  in  DP_PACKET  instruction being dispatched
- cdb_packet  in  CDB_PACKET  broadcast result: rob_tag, value; rob_tag==0 means idle
- map_rob_packet  in  MAP_ROB_PACKET  map-table lookup of rs1/rs2 for the dispatching instruction
- rob_map_packet  out  ROB_MAP_PACKET  rob_new_tail {rob_tag, dp_packet}, rob_head {rob_tag, dp_packet, value}, retire_valid
- rob_rs_packet  out  ROB_RS_PACKET  value_a/value_b plus ready_a/ready_b for forwarded operands
- rob_full  out  1  structural stall to dispatch
- rob_dbg  out  ROB_ENTRY [ROB_SZ-1:0]  entry array

Behaviour:
- Entry fields: valid, complete, rob_tag, dp_packet, value.
- State: head and tail pointers, log2(ROB_SZ) bits each, wrapping modulo ROB_SZ; count, TAG_W bits.
- Tag of slot i is i+1, so a tag is never 0.
- Reset: all entries invalid; head=tail=count=0; retire_valid=0; rob_full=0.
- rob_new_tail is combinational from the tail slot: {tail+1, dp_packet}. It is valid only when dispatch_valid && !rob_full.
- Dispatch: on posedge with dispatch_valid && !rob_full, write the tail slot (valid=1, complete=0, value=0, dp_packet) and advance tail.
- dispatch_valid while rob_full is ignored; no state change.
- Complete: on posedge with cdb_packet.rob_tag!=0 and matching a valid entry, set complete=1 and store value. A tag matching no valid entry is ignored.
- Retire: retire_valid = head entry valid && complete, combinational from registered state.
- rob_head always shows the head slot. When retire_valid, on posedge the head slot is invalidated and head advances.
- Retire and dispatch are capped at one each per cycle.
- count: +1 on dispatch, −1 on retire, unchanged when both occur.
- rob_full = (count==ROB_SZ), from registered count only; no same-cycle retire bypass.
- CDB completing the head entry: retire_valid asserts the following cycle (1-cycle complete-to-retire latency).
- Operand forwarding, channel a (b identical), in priority order:
  1. If map_packet_a.rob_tag==0: ready_a=0, value_a=0 (RS reads the regfile).
  2. Else if the entry is complete: ready_a=1 with the stored value.
  3. Else if cdb_packet.rob_tag==map_packet_a.rob_tag this cycle: ready_a=1 with the CDB value (bypass).
  4. Else ready_a=0.
- Wrap-around: tail==head with count==ROB_SZ means full; with count==0 it means empty. Tags are reused after retire.
- Reset mid-operation drops all entries with no retire.

Optional Feature:
- ROB_SQUASH_EN defined:
  - Adds input squash (1 bit).
  - On posedge with squash=1: all entries invalid, head=tail=count=0, same as reset but without affecting other blocks.
  - Squash overrides a same-cycle dispatch, complete or retire.
  - retire_valid is still driven combinationally from registered state during the squash cycle; consumers ignore it when squash=1.
- Undefined: no squash port; flush only through reset.

Decomposition:
- sys_defs.svh: ROB_SZ, ROB_TAG width, ROB_ENTRY, ROB_MAP_PACKET, ROB_RS_PACKET (extended with ready bits), and the shared MAP_ROB_PACKET/CDB_PACKET types.
- One natural sub-module, rob_operand_fwd: combinational tag→value lookup with CDB bypass, instantiated twice (a, b).

Test Plan:
- Reset, then dispatch 3 instructions on consecutive cycles → rob_new_tail.rob_tag 1,2,3; count=3; retire_valid=0.
- CDB tag 2 value 0x55, then tag 1 value 0x11 → retire tag 1 (value 0x11) the cycle after the tag-1 completion, then retire tag 2 (value 0x55) the next cycle; tag 3 stays.
- Fill 8 entries → rob_full=1; a 9th dispatch_valid changes nothing. Complete and retire tag 1 → rob_full=0; the next dispatch gets tag 1 (wrap-around).
- map_packet_a.rob_tag=4 incomplete, same-cycle CDB tag 4 value 0xAB → ready_a=1, value_a=0xAB. map_packet_b.rob_tag=0 → ready_b=0.
- Full ROB, head complete, dispatch_valid=1 → retire occurs; dispatch is blocked this cycle; count becomes 7.
- ROB_SQUASH_EN: 5 entries live, squash=1 alongside dispatch_valid → next cycle count=0, rob_full=0, retire_valid=0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer and its neighbours (map table, RS, CDB).
// ROB tags are 1-based: slot i carries tag i+1, and tag 0 means "value is in
// the register file".
package reorder_buffer_pkg;

  localparam int ROB_SZ = 8;
  localparam int TAG_W  = $clog2(ROB_SZ + 1);
  localparam int PTR_W  = $clog2(ROB_SZ);
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef logic [TAG_W-1:0] ROB_TAG;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic              has_dest;
  } DP_PACKET;

  typedef struct packed {
    ROB_TAG            rob_tag;
    logic [DATA_W-1:0] value;
  } CDB_PACKET;

  typedef struct packed {
    ROB_TAG rob_tag;
  } MAP_PACKET;

  typedef struct packed {
    MAP_PACKET map_packet_a;
    MAP_PACKET map_packet_b;
  } MAP_ROB_PACKET;

  typedef struct packed {
    logic              valid;
    logic              complete;
    ROB_TAG            rob_tag;
    DP_PACKET          dp_packet;
    logic [DATA_W-1:0] value;
  } ROB_ENTRY;

  typedef struct packed {
    ROB_TAG   rob_tag;
    DP_PACKET dp_packet;
  } ROB_NEW_TAIL;

  typedef struct packed {
    ROB_TAG            rob_tag;
    DP_PACKET          dp_packet;
    logic [DATA_W-1:0] value;
  } ROB_HEAD;

  typedef struct packed {
    ROB_NEW_TAIL rob_new_tail;
    ROB_HEAD     rob_head;
    logic        retire_valid;
  } ROB_MAP_PACKET;

  typedef struct packed {
    logic [DATA_W-1:0] value_a;
    logic [DATA_W-1:0] value_b;
    logic              ready_a;
    logic              ready_b;
  } ROB_RS_PACKET;

  // Slot index to its (never zero) tag.
  function automatic ROB_TAG slot_to_tag(input logic [PTR_W-1:0] slot);
    return ROB_TAG'(slot) + ROB_TAG'(1);
  endfunction

  // Tag back to its slot; only meaningful for nonzero tags.
  function automatic logic [PTR_W-1:0] tag_to_slot(input ROB_TAG tag);
    ROB_TAG t;
    t = tag - ROB_TAG'(1);
    return t[PTR_W-1:0];
  endfunction

endpackage

// File: rtl/reorder_buffer_operand_fwd.sv
// rob_operand_fwd: resolves one renamed source operand against the ROB.
// Priority: tag 0 (regfile) -> completed entry -> same-cycle CDB bypass.
module rob_operand_fwd
  import reorder_buffer_pkg::*;
(
  input  ROB_TAG                  tag,
  input  ROB_ENTRY [ROB_SZ-1:0]   entries,
  input  CDB_PACKET               cdb_packet,
  output logic                    ready,
  output logic [DATA_W-1:0]       value
);

  logic [PTR_W-1:0] slot;
  ROB_ENTRY         entry;

  // Tag lookup with CDB bypass for results broadcast this very cycle.
  always_comb begin
    slot  = tag_to_slot(tag);
    entry = entries[slot];
    ready = 1'b0;
    value = '0;
    if (tag == '0) begin
      ready = 1'b0;
    end else if (entry.valid && entry.complete) begin
      ready = 1'b1;
      value = entry.value;
    end else if (cdb_packet.rob_tag == tag) begin
      ready = 1'b1;
      value = cdb_packet.value;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at tail on dispatch, records
// CDB results, retires the head in program order (at most one per cycle).
// Optional macro ROB_SQUASH_EN adds a 'squash' input that flushes the buffer
// like reset without touching other blocks.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dispatch_valid,
  input  DP_PACKET              dp_packet,
  input  CDB_PACKET             cdb_packet,
  input  MAP_ROB_PACKET         map_rob_packet,
  output ROB_MAP_PACKET         rob_map_packet,
  output ROB_RS_PACKET          rob_rs_packet,
  output logic                  rob_full,
  output ROB_ENTRY [ROB_SZ-1:0] rob_dbg
`ifdef ROB_SQUASH_EN
  ,
  input  logic                  squash
`endif
);

  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam ROB_TAG           FULL_COUNT = ROB_TAG'(ROB_SZ);

  // Control state (reset / squash cleared).
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  ROB_TAG            count;
  logic [ROB_SZ-1:0] valid_q;
  logic [ROB_SZ-1:0] complete_q;

  // Payload storage (never reset; qualified by valid_q).
  logic [DATA_W-1:0] value_q [ROB_SZ];
  DP_PACKET          dp_q    [ROB_SZ];

  logic             flush;
  logic             dispatch_fire;
  logic             retire_valid;
  logic             cdb_hit;
  logic [PTR_W-1:0] cdb_slot;

`ifdef ROB_SQUASH_EN
  assign flush = squash;
`else
  assign flush = 1'b0;
`endif

  assign rob_full      = (count == FULL_COUNT);
  assign dispatch_fire = dispatch_valid && !rob_full;
  assign retire_valid  = valid_q[head] && complete_q[head];
  assign cdb_slot      = tag_to_slot(cdb_packet.rob_tag);
  assign cdb_hit       = (cdb_packet.rob_tag != '0) && valid_q[cdb_slot];

  // Pointer, count and per-entry status bits; retire is coded after the CDB
  // write so it wins if both touch the head slot.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      valid_q    <= '0;
      complete_q <= '0;
    end else begin
      if (cdb_hit) begin
        complete_q[cdb_slot] <= 1'b1;
      end
      if (retire_valid) begin
        valid_q[head]    <= 1'b0;
        complete_q[head] <= 1'b0;
        head             <= head + PTR_ONE;
      end
      if (dispatch_fire) begin
        valid_q[tail]    <= 1'b1;
        complete_q[tail] <= 1'b0;
        tail             <= tail + PTR_ONE;
      end
      case ({dispatch_fire, retire_valid})
        2'b10:   count <= count + ROB_TAG'(1);
        2'b01:   count <= count - ROB_TAG'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload capture: instruction on dispatch, result on CDB hit.
  always_ff @(posedge clock) begin
    if (cdb_hit) begin
      value_q[cdb_slot] <= cdb_packet.value;
    end
    if (dispatch_fire) begin
      value_q[tail] <= '0;
      dp_q[tail]    <= dp_packet;
    end
  end

  // Assemble the entry view consumed by forwarding and debug.
  always_comb begin
    for (int i = 0; i < ROB_SZ; i++) begin
      rob_dbg[i].valid     = valid_q[i];
      rob_dbg[i].complete  = complete_q[i];
      rob_dbg[i].rob_tag   = slot_to_tag(PTR_W'(i));
      rob_dbg[i].dp_packet = dp_q[i];
      rob_dbg[i].value     = value_q[i];
    end
  end

  // Map-table facing view of the tail (allocation) and head (retirement).
  always_comb begin
    rob_map_packet.rob_new_tail.rob_tag   = slot_to_tag(tail);
    rob_map_packet.rob_new_tail.dp_packet = dp_packet;
    rob_map_packet.rob_head.rob_tag       = slot_to_tag(head);
    rob_map_packet.rob_head.dp_packet     = dp_q[head];
    rob_map_packet.rob_head.value         = value_q[head];
    rob_map_packet.retire_valid           = retire_valid;
  end

  rob_operand_fwd u_fwd_a (
    .tag        (map_rob_packet.map_packet_a.rob_tag),
    .entries    (rob_dbg),
    .cdb_packet (cdb_packet),
    .ready      (rob_rs_packet.ready_a),
    .value      (rob_rs_packet.value_a)
  );

  rob_operand_fwd u_fwd_b (
    .tag        (map_rob_packet.map_packet_b.rob_tag),
    .entries    (rob_dbg),
    .cdb_packet (cdb_packet),
    .ready      (rob_rs_packet.ready_b),
    .value      (rob_rs_packet.value_b)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected retirements are queued as
// completions are issued; a negedge monitor pops and compares each retire.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  dispatch_valid;
  DP_PACKET              dp_packet;
  CDB_PACKET             cdb_packet;
  MAP_ROB_PACKET         map_rob_packet;
  ROB_MAP_PACKET         rob_map_packet;
  ROB_RS_PACKET          rob_rs_packet;
  logic                  rob_full;
  ROB_ENTRY [ROB_SZ-1:0] rob_dbg;
  logic                  squash_tb;

  typedef struct {
    ROB_TAG            tag;
    logic [DATA_W-1:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  reorder_buffer dut (
    .clock          (clock),
    .reset          (reset),
    .dispatch_valid (dispatch_valid),
    .dp_packet      (dp_packet),
    .cdb_packet     (cdb_packet),
    .map_rob_packet (map_rob_packet),
    .rob_map_packet (rob_map_packet),
    .rob_rs_packet  (rob_rs_packet),
    .rob_full       (rob_full),
    .rob_dbg        (rob_dbg)
`ifdef ROB_SQUASH_EN
    ,
    .squash         (squash_tb)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic int live_count();
    int n = 0;
    for (int i = 0; i < ROB_SZ; i++) if (rob_dbg[i].valid) n++;
    return n;
  endfunction

  function automatic DP_PACKET mk_dp(input int k);
    DP_PACKET d;
    d.pc       = 32'h1000 + 32'(k) * 4;
    d.rd       = k[4:0];
    d.rs1      = k[4:0] + 5'd1;
    d.rs2      = k[4:0] + 5'd2;
    d.has_dest = 1'b1;
    return d;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cdb(input int tag, input logic [DATA_W-1:0] val);
    cdb_packet.rob_tag = ROB_TAG'(tag);
    cdb_packet.value   = val;
  endtask

  // Retirement monitor: every retire must match the next queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && !squash_tb && rob_map_packet.retire_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_retire actual_tag=%0d required=none",
                 rob_map_packet.rob_head.rob_tag);
      end else begin
        e = exp_q.pop_front();
        check("retire_tag", 64'(rob_map_packet.rob_head.rob_tag), 64'(e.tag));
        check("retire_value", 64'(rob_map_packet.rob_head.value), 64'(e.value));
      end
    end
  end

  initial begin
    reset          = 1'b1;
    dispatch_valid = 1'b0;
    dp_packet      = '0;
    cdb_packet     = '0;
    map_rob_packet = '0;
    squash_tb      = 1'b0;
    step();
    step();
    reset = 1'b0;
    @(negedge clock);
    check("reset_full", 64'(rob_full), 64'd0);
    check("reset_retire_valid", 64'(rob_map_packet.retire_valid), 64'd0);
    check("reset_count", 64'(live_count()), 64'd0);
    check("reset_new_tail_tag", 64'(rob_map_packet.rob_new_tail.rob_tag), 64'd1);
    step();

    // Three consecutive dispatches get tags 1, 2, 3.
    for (int k = 0; k < 3; k++) begin
      dispatch_valid = 1'b1;
      dp_packet      = mk_dp(k);
      @(negedge clock);
      check("dispatch_new_tail_tag", 64'(rob_map_packet.rob_new_tail.rob_tag), 64'(k + 1));
      step();
    end
    dispatch_valid = 1'b0;
    @(negedge clock);
    check("three_count", 64'(live_count()), 64'd3);
    check("three_retire_valid", 64'(rob_map_packet.retire_valid), 64'd0);
    step();

    // Out-of-order completion, in-order retirement.
    set_cdb(2, 32'h55);
    step();
    set_cdb(1, 32'h11);
    exp_q.push_back('{tag: ROB_TAG'(1), value: 32'h11});
    exp_q.push_back('{tag: ROB_TAG'(2), value: 32'h55});
    @(negedge clock);
    check("tag2_done_no_retire", 64'(rob_map_packet.retire_valid), 64'd0);
    step();
    set_cdb(0, 32'h0);
    step();
    step();
    @(negedge clock);
    check("tag3_stays_count", 64'(live_count()), 64'd1);
    check("tag3_not_retiring", 64'(rob_map_packet.retire_valid), 64'd0);
    check("tag3_head_tag", 64'(rob_map_packet.rob_head.rob_tag), 64'd3);
    check("scoreboard_drained_1", 64'(exp_q.size()), 64'd0);
    step();

    // Reset mid-operation drops the remaining entry.
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    check("midreset_count", 64'(live_count()), 64'd0);
    check("midreset_head_tag", 64'(rob_map_packet.rob_head.rob_tag), 64'd1);
    step();

    // Fill all eight slots.
    for (int k = 0; k < ROB_SZ; k++) begin
      dispatch_valid = 1'b1;
      dp_packet      = mk_dp(10 + k);
      step();
    end
    // Ninth dispatch while full, plus CDB bypass of tag 4 on operand a.
    dp_packet = mk_dp(99);
    map_rob_packet.map_packet_a.rob_tag = ROB_TAG'(4);
    map_rob_packet.map_packet_b.rob_tag = ROB_TAG'(0);
    set_cdb(4, 32'hAB);
    @(negedge clock);
    check("fill_full", 64'(rob_full), 64'd1);
    check("fill_count", 64'(live_count()), 64'd8);
    check("bypass_ready_a", 64'(rob_rs_packet.ready_a), 64'd1);
    check("bypass_value_a", 64'(rob_rs_packet.value_a), 64'hAB);
    check("tag0_ready_b", 64'(rob_rs_packet.ready_b), 64'd0);
    check("tag0_value_b", 64'(rob_rs_packet.value_b), 64'd0);
    step();
    dispatch_valid = 1'b0;
    set_cdb(0, 32'h0);
    map_rob_packet.map_packet_b.rob_tag = ROB_TAG'(5);
    @(negedge clock);
    check("ninth_ignored_full", 64'(rob_full), 64'd1);
    check("ninth_ignored_count", 64'(live_count()), 64'd8);
    check("ninth_ignored_slot0_pc", 64'(rob_dbg[0].dp_packet.pc), 64'(mk_dp(10).pc));
    check("stored_ready_a", 64'(rob_rs_packet.ready_a), 64'd1);
    check("stored_value_a", 64'(rob_rs_packet.value_a), 64'hAB);
    check("incomplete_ready_b", 64'(rob_rs_packet.ready_b), 64'd0);
    step();

    // Complete head, then retire while full with dispatch attempted.
    set_cdb(1, 32'h77);
    exp_q.push_back('{tag: ROB_TAG'(1), value: 32'h77});
    step();
    set_cdb(0, 32'h0);
    dispatch_valid = 1'b1;
    dp_packet      = mk_dp(50);
    @(negedge clock);
    check("retire_cycle_still_full", 64'(rob_full), 64'd1);
    step();
    dispatch_valid = 1'b0;
    @(negedge clock);
    check("after_retire_count", 64'(live_count()), 64'd7);
    check("after_retire_full", 64'(rob_full), 64'd0);
    check("after_retire_slot0_valid", 64'(rob_dbg[0].valid), 64'd0);
    step();
    dispatch_valid = 1'b1;
    dp_packet      = mk_dp(60);
    @(negedge clock);
    check("wrap_new_tail_tag", 64'(rob_map_packet.rob_new_tail.rob_tag), 64'd1);
    step();
    dispatch_valid = 1'b0;
    @(negedge clock);
    check("wrap_full", 64'(rob_full), 64'd1);
    check("wrap_count", 64'(live_count()), 64'd8);
    check("wrap_slot0_pc", 64'(rob_dbg[0].dp_packet.pc), 64'(mk_dp(60).pc));
    check("wrap_slot0_complete", 64'(rob_dbg[0].complete), 64'd0);
    check("tag4_complete", 64'(rob_dbg[3].complete), 64'd1);
    check("tag4_value", 64'(rob_dbg[3].value), 64'hAB);
    check("scoreboard_drained_2", 64'(exp_q.size()), 64'd0);
    step();

`ifdef ROB_SQUASH_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      dispatch_valid = 1'b1;
      dp_packet      = mk_dp(70 + k);
      step();
    end
    squash_tb = 1'b1;
    @(negedge clock);
    check("presquash_count", 64'(live_count()), 64'd5);
    step();
    squash_tb      = 1'b0;
    dispatch_valid = 1'b0;
    @(negedge clock);
    check("squash_count", 64'(live_count()), 64'd0);
    check("squash_full", 64'(rob_full), 64'd0);
    check("squash_retire_valid", 64'(rob_map_packet.retire_valid), 64'd0);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
